// File: rtl/fifo_dpram_ctrl_pkg.sv
// Shared sizing constants for the dual-port-RAM FIFO controller.
package fifo_dpram_ctrl_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 8;
  localparam int unsigned FIFO_ADDR_WIDTH = 6;
  localparam int unsigned FIFO_DEPTH      = 2 ** FIFO_ADDR_WIDTH;
  localparam int unsigned FIFO_AF_LEVEL   = 56;
  localparam int unsigned FIFO_AE_LEVEL   = 8;

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Write/read pointer and occupancy count registers for the FIFO controller.
// Pointers wrap naturally at 2**ADDR_WIDTH; the count is one bit wider to reach full depth.
module fifo_ptr_cnt #(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push_ok_i,
  input  logic                  pop_ok_i,
  output logic [ADDR_WIDTH-1:0] wr_ptr_o,
  output logic [ADDR_WIDTH-1:0] rd_ptr_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  logic [ADDR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_d, count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_i) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (pop_ok_i)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({push_ok_i, pop_ok_i})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

endmodule

// File: rtl/fifo_dpram_ctrl.sv
// FIFO controller driving an external true dual-port RAM (port A write, port B read, latency 1).
// Define FIFO_ALMOST_FLAGS_EN to enable the almost_full/almost_empty threshold comparators.
module fifo_dpram_ctrl
  import fifo_dpram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int unsigned AF_LEVEL   = FIFO_AF_LEVEL,
  parameter int unsigned AE_LEVEL   = FIFO_AE_LEVEL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  err_ovf,
  output logic                  err_udf,
  output logic                  we_a,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0] data_a,
  output logic                  we_b,
  output logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] q_b
);

  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH+1)'(2 ** ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  push_ok, pop_ok;
  logic                  valid_d, valid_q;

  assign full  = (fifo_count == DepthCnt);
  assign empty = (fifo_count == '0);

  // Requests in a reset cycle are dropped so nothing is written or returned across a reset.
  assign push_ok = push && !full && !reset;
  assign pop_ok  = pop && !empty && !reset;
  assign err_ovf = push && full && !reset;
  assign err_udf = pop && empty && !reset;

  fifo_ptr_cnt #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ptr_cnt (
    .clk_i     (clk),
    .reset_i   (reset),
    .push_ok_i (push_ok),
    .pop_ok_i  (pop_ok),
    .wr_ptr_o  (wr_ptr),
    .rd_ptr_o  (rd_ptr),
    .count_o   (fifo_count)
  );

  assign we_a   = push_ok;
  assign addr_a = wr_ptr;
  assign data_a = data_in;
  assign we_b   = 1'b0;
  assign addr_b = rd_ptr;

  always_comb begin
    valid_d = pop_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  // The RAM registers its output, so q_b already lines up with valid_q.
  assign valid_out = valid_q;
  assign data_out  = q_b;

`ifdef FIFO_ALMOST_FLAGS_EN
  assign almost_full  = (fifo_count >= (ADDR_WIDTH+1)'(AF_LEVEL));
  assign almost_empty = (fifo_count <= (ADDR_WIDTH+1)'(AE_LEVEL));
`else
  // Folds to constant 0; the levels stay referenced so both builds share one parameter set.
  assign almost_full  = 1'b0 & (AF_LEVEL > AE_LEVEL);
  assign almost_empty = 1'b0 & (AF_LEVEL > AE_LEVEL);
`endif

endmodule

// File: tb/tb_fifo_dpram_ctrl.sv
// Directed bench for fifo_dpram_ctrl with a behavioural dual-port RAM (registered port B).
module tb_fifo_dpram_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       push, pop;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       valid_out, full, empty, almost_full, almost_empty;
  logic [6:0] fifo_count;
  logic       err_ovf, err_udf;
  logic       we_a, we_b;
  logic [5:0] addr_a, addr_b;
  logic [7:0] data_a, q_b;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [64];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_a;
    q_b <= mem[addr_b];
  end

  fifo_dpram_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_count   (fifo_count),
    .err_ovf      (err_ovf),
    .err_udf      (err_udf),
    .we_a         (we_a),
    .addr_a       (addr_a),
    .data_a       (data_a),
    .we_b         (we_b),
    .addr_b       (addr_b),
    .q_b          (q_b)
  );

  function automatic logic exp_af(input int cnt);
`ifdef FIFO_ALMOST_FLAGS_EN
    return cnt >= 56;
`else
    return (cnt < 0);
`endif
  endfunction

  function automatic logic exp_ae(input int cnt);
`ifdef FIFO_ALMOST_FLAGS_EN
    return cnt <= 8;
`else
    return (cnt < 0);
`endif
  endfunction

  task automatic drive(input logic p, input logic q, input logic [7:0] d);
    push = p; pop = q; data_in = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    if (we_a !== 1'b0) begin bad++; $display("FAIL rst_we_a got=%0b want=0", we_a); end
    total++;
    tick(); tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    total++;
    if (fifo_count !== 7'd0 || empty !== 1'b1 || full !== 1'b0) begin
      bad++;
      $display("FAIL rst_flags got cnt=%0d e=%0b f=%0b want cnt=0 e=1 f=0", fifo_count, empty, full);
    end
    total++;
    if (valid_out !== 1'b0 || err_ovf !== 1'b0 || err_udf !== 1'b0 || we_b !== 1'b0) begin
      bad++;
      $display("FAIL rst_strobes got v=%0b o=%0b u=%0b wb=%0b want 0", valid_out, err_ovf, err_udf,
               we_b);
    end
    total++;
    if (almost_full !== exp_af(0) || almost_empty !== exp_ae(0)) begin
      bad++;
      $display("FAIL rst_almost got af=%0b ae=%0b want af=%0b ae=%0b", almost_full, almost_empty,
               exp_af(0), exp_ae(0));
    end
  endtask

  task automatic test_basic();
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, vals[i]);
      total++;
      if (we_a !== 1'b1 || addr_a !== 6'(i) || data_a !== vals[i]) begin
        bad++;
        $display("FAIL basic_write%0d got we=%0b a=%0d d=%h want we=1 a=%0d d=%h", i, we_a, addr_a,
                 data_a, i, vals[i]);
      end
      tick();
    end
    drive(1'b0, 1'b0, 8'h00);
    total++;
    if (fifo_count !== 7'd3 || valid_out !== 1'b0) begin
      bad++; $display("FAIL basic_count got=%0d v=%0b want=3 v=0", fifo_count, valid_out);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      total++;
      if (addr_b !== 6'(i) || we_a !== 1'b0) begin
        bad++; $display("FAIL basic_raddr%0d got=%0d we=%0b want=%0d", i, addr_b, we_a, i);
      end
      tick();
      total++;
      if (valid_out !== 1'b1 || data_out !== vals[i]) begin
        bad++;
        $display("FAIL basic_read%0d got v=%0b d=%h want v=1 d=%h", i, valid_out, data_out, vals[i]);
      end
    end
    drive(1'b0, 1'b0, 8'h00);
    total++;
    if (empty !== 1'b1 || fifo_count !== 7'd0) begin
      bad++; $display("FAIL basic_empty got e=%0b cnt=%0d want e=1 cnt=0", empty, fifo_count);
    end
    tick();
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL basic_valid_drop got=%0b want=0", valid_out); end
  endtask

  task automatic test_underflow();
    drive(1'b0, 1'b1, 8'h00);
    total++;
    if (err_udf !== 1'b1 || err_ovf !== 1'b0) begin
      bad++; $display("FAIL udf_pulse got u=%0b o=%0b want u=1 o=0", err_udf, err_ovf);
    end
    tick();
    total++;
    if (valid_out !== 1'b0 || fifo_count !== 7'd0) begin
      bad++; $display("FAIL udf_noread got v=%0b cnt=%0d want v=0 cnt=0", valid_out, fifo_count);
    end
    drive(1'b1, 1'b1, 8'h5A);
    total++;
    if (err_udf !== 1'b1 || we_a !== 1'b1 || addr_a !== 6'd3) begin
      bad++; $display("FAIL udf_pushpop got u=%0b we=%0b a=%0d want u=1 we=1 a=3", err_udf, we_a, addr_a);
    end
    tick();
    drive(1'b0, 1'b0, 8'h00);
    total++;
    if (fifo_count !== 7'd1 || valid_out !== 1'b0 || err_udf !== 1'b0) begin
      bad++;
      $display("FAIL udf_after got cnt=%0d v=%0b u=%0b want cnt=1 v=0 u=0", fifo_count, valid_out,
               err_udf);
    end
    drive(1'b0, 1'b1, 8'h00);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    total++;
    if (valid_out !== 1'b1 || data_out !== 8'h5A || empty !== 1'b1) begin
      bad++; $display("FAIL udf_drain got v=%0b d=%h e=%0b want v=1 d=5a e=1", valid_out, data_out, empty);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 1'b0, 8'(8'h40 + i));
      tick();
      drive(1'b0, 1'b0, 8'h00);
      total++;
      if (fifo_count !== 7'(i + 1) || almost_full !== exp_af(i + 1) ||
          almost_empty !== exp_ae(i + 1) || full !== (i == 63)) begin
        bad++;
        $display("FAIL fill%0d got cnt=%0d af=%0b ae=%0b f=%0b want cnt=%0d af=%0b ae=%0b f=%0b", i,
                 fifo_count, almost_full, almost_empty, full, i + 1, exp_af(i + 1), exp_ae(i + 1),
                 i == 63);
      end
    end
    drive(1'b1, 1'b0, 8'hEE);
    total++;
    if (err_ovf !== 1'b1 || we_a !== 1'b0 || addr_a !== 6'd4) begin
      bad++; $display("FAIL ovf_pulse got o=%0b we=%0b a=%0d want o=1 we=0 a=4", err_ovf, we_a, addr_a);
    end
    tick();
    drive(1'b0, 1'b0, 8'h00);
    total++;
    if (fifo_count !== 7'd64 || full !== 1'b1 || addr_a !== 6'd4 || err_ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_hold got cnt=%0d f=%0b a=%0d o=%0b want cnt=64 f=1 a=4 o=0", fifo_count, full,
               addr_a, err_ovf);
    end
    drive(1'b1, 1'b1, 8'h77);
    total++;
    if (err_ovf !== 1'b1 || err_udf !== 1'b0 || we_a !== 1'b0 || addr_b !== 6'd4) begin
      bad++;
      $display("FAIL full_pushpop got o=%0b u=%0b we=%0b ab=%0d want o=1 u=0 we=0 ab=4", err_ovf,
               err_udf, we_a, addr_b);
    end
    tick();
    total++;
    if (fifo_count !== 7'd63 || valid_out !== 1'b1 || data_out !== 8'h40) begin
      bad++;
      $display("FAIL full_pop got cnt=%0d v=%0b d=%h want cnt=63 v=1 d=40", fifo_count, valid_out,
               data_out);
    end
    for (int i = 1; i < 64; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      tick();
      total++;
      if (valid_out !== 1'b1 || data_out !== 8'(8'h40 + i)) begin
        bad++;
        $display("FAIL drain%0d got v=%0b d=%h want v=1 d=%h", i, valid_out, data_out, 8'(8'h40 + i));
      end
    end
    drive(1'b0, 1'b0, 8'h00);
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0b want=1", empty); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      tick();
    end
    for (int j = 0; j < 100; j++) begin
      drive(1'b1, 1'b1, 8'(10 + j));
      total++;
      if (addr_a !== 6'(14 + j) || addr_b !== 6'(4 + j) || we_a !== 1'b1) begin
        bad++;
        $display("FAIL b2b_addr%0d got wa=%0d rb=%0d we=%0b want wa=%0d rb=%0d", j, addr_a, addr_b,
                 we_a, 6'(14 + j), 6'(4 + j));
      end
      tick();
      total++;
      if (fifo_count !== 7'd10 || valid_out !== 1'b1 || data_out !== 8'(j)) begin
        bad++;
        $display("FAIL b2b_data%0d got cnt=%0d v=%0b d=%h want cnt=10 v=1 d=%h", j, fifo_count,
                 valid_out, data_out, 8'(j));
      end
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      tick();
      total++;
      if (valid_out !== 1'b1 || data_out !== 8'(100 + i)) begin
        bad++;
        $display("FAIL b2b_drain%0d got v=%0b d=%h want v=1 d=%h", i, valid_out, data_out, 8'(100 + i));
      end
    end
    drive(1'b0, 1'b0, 8'h00);
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%0b want=1", empty); end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 8'(8'hA0 + i));
      tick();
    end
    drive(1'b0, 1'b0, 8'h00);
    total++;
    if (fifo_count !== 7'd20) begin bad++; $display("FAIL mid_fill got=%0d want=20", fifo_count); end
    reset = 1'b1;
    drive(1'b0, 1'b1, 8'h00);
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    total++;
    if (fifo_count !== 7'd0 || empty !== 1'b1 || valid_out !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got cnt=%0d e=%0b v=%0b want cnt=0 e=1 v=0", fifo_count, empty,
               valid_out);
    end
    drive(1'b1, 1'b0, 8'hC3);
    total++;
    if (addr_a !== 6'd0 || we_a !== 1'b1) begin
      bad++; $display("FAIL mid_wptr got a=%0d we=%0b want a=0 we=1", addr_a, we_a);
    end
    tick();
    drive(1'b0, 1'b1, 8'h00);
    total++;
    if (addr_b !== 6'd0) begin bad++; $display("FAIL mid_rptr got=%0d want=0", addr_b); end
    tick();
    total++;
    if (valid_out !== 1'b1 || data_out !== 8'hC3) begin
      bad++; $display("FAIL mid_read got v=%0b d=%h want v=1 d=c3", valid_out, data_out);
    end
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = 8'h00;
    test_reset();
    test_basic();
    test_underflow();
    test_full();
    test_back_to_back();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_dpram_ctrl.md
FIFO_DPRAM_CTRL -- requirements
Module: fifo_dpram_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_WIDTH, 8, word width; matches the dual-port RAM data ports.
  ADDR_WIDTH, 6, RAM address width; depth = 2**ADDR_WIDTH = 64.
  AF_LEVEL, 56, almost_full asserts when count >= AF_LEVEL.
  AE_LEVEL, 8, almost_empty asserts when count <= AE_LEVEL.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock; all logic on rising edge.
  reset  in  1  synchronous, active-high reset.
  push  in  1  write request.
  data_in  in  DATA_WIDTH  write data.
  pop  in  1  read request.
  data_out  out  DATA_WIDTH  read data.
  valid_out  out  1  data_out valid strobe.
  full, empty  out  1 each  occupancy flags.
  almost_full, almost_empty  out  1 each  threshold flags (see REQ-019).
  fifo_count  out  ADDR_WIDTH+1  current occupancy, 0..64.
  err_ovf, err_udf  out  1 each  rejected push / rejected pop, one-cycle pulse.
  we_a, addr_a, data_a  out  1/ADDR_WIDTH/DATA_WIDTH  RAM port A (write side).
  we_b, addr_b  out  1/ADDR_WIDTH  RAM port B (read side); we_b constant 0.
  q_b  in  DATA_WIDTH  RAM port B registered read data.
REQ-003 One clock and a synchronous, active-high reset SHALL be used: clk and reset; polarity and synchronicity are fixed.

Function
REQ-004 Write pointer wr_ptr and read pointer rd_ptr SHALL be ADDR_WIDTH bits each and wrap from 63 to 0.
REQ-005 A push SHALL be accepted iff push=1 and full=0, regardless of pop.
REQ-006 A pop SHALL be accepted iff pop=1 and empty=0, regardless of push.
REQ-007 On an accepted push: we_a=1, addr_a=wr_ptr, data_a=data_in, all combinational in the same cycle; wr_ptr increments at the edge.
REQ-008 Outside an accepted push, we_a SHALL be 0.
REQ-009 On an accepted pop: addr_b=rd_ptr in the same cycle; rd_ptr increments at the edge.
REQ-010 data_out SHALL equal q_b, and valid_out SHALL be 1, exactly one cycle after an accepted pop (read latency 1); otherwise valid_out=0.
REQ-011 fifo_count SHALL update at the edge: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-012 full = (fifo_count==64); empty = (fifo_count==0); both registered-state derived with no extra latency.
REQ-013 A rejected push SHALL pulse err_ovf for one cycle and leave the RAM and pointers unchanged.
REQ-014 A rejected pop SHALL pulse err_udf for one cycle.
REQ-015 Simultaneous accepted push and pop with 0<count<64 SHALL write and read different addresses and keep the count constant.
REQ-016 Push and pop asserted together while empty: push accepted, err_udf=1; while full: pop accepted, err_ovf=1.

Reset
REQ-017 While reset=1 at an edge: wr_ptr=rd_ptr=0, fifo_count=0, valid_out=0, err_ovf=err_udf=0; empty=1, full=0; we_a=0.
REQ-018 A reset during operation SHALL discard all contents; a pop accepted in the reset cycle SHALL NOT produce valid_out. RAM contents are not cleared.

Configuration
REQ-019 Macro FIFO_ALMOST_FLAGS_EN: when defined, almost_full=(count>=AF_LEVEL) and almost_empty=(count<=AE_LEVEL); when undefined, both outputs SHALL be tied to 0 and no comparator logic is synthesized.

Structure
REQ-020 A shared package SHALL hold DATA_WIDTH, ADDR_WIDTH, DEPTH and the default AF_LEVEL/AE_LEVEL constants.
REQ-021 A single sub-module, fifo_ptr_cnt (pointer and count register block), is natural; flag and RAM-port logic stays at top level.
REQ-022 The block SHALL connect directly to the existing true dual-port RAM: port A for writes, port B for reads.

Verification
REQ-023 Reset, then push 0x11,0x22,0x33 -> count=3; three pops -> data_out 0x11,0x22,0x33 each one cycle after pop; empty=1.
REQ-024 Push 64 words -> full=1 at count 64; 65th push -> err_ovf pulse, count stays 64, wr_ptr unchanged.
REQ-025 Pop on empty -> err_udf pulse, valid_out=0; push+pop on empty -> count=1, err_udf=1.
REQ-026 Fill to 10, then 100 cycles of push+pop with incrementing data -> count stays 10, pointers wrap past 63, data order preserved.
REQ-027 With FIFO_ALMOST_FLAGS_EN: counts 8->9 deassert almost_empty, 55->56 assert almost_full; without it both stay 0.
REQ-028 Reset asserted at count 20 with pop=1 -> next cycle count=0, empty=1, valid_out=0.
